// File: rtl/prog_loader_pkg.sv
// Shared definitions for the instruction loader: default geometry and FSM state encodings.
package prog_loader_pkg;

    localparam int DEF_ADDR_W = 4;
    localparam int DEF_DEPTH  = 16;
    localparam int DEF_HALF_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HI   = 3'd1,
        ST_LO   = 3'd2,
        ST_WR   = 3'd3,
        ST_CHK  = 3'd4,
        ST_DONE = 3'd5
    } state_e;

endpackage

// File: rtl/prog_loader.sv
// Streams halfword pairs into the CPU instruction memory, checks an XOR checksum,
// then releases the CPU from reset.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int HALF_W = DEF_HALF_W
) (
    input  logic                clk,
    input  logic                sys_rst,
    input  logic                start,
    input  logic [ADDR_W:0]     num_words,
    input  logic [HALF_W-1:0]   in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [2*HALF_W-1:0] mem_wdata,
    output logic                cpu_rst,
    output logic                busy,
    output logic                done,
    output logic                chk_err
);

    state_e              state_q,   state_d;
    logic [ADDR_W:0]     len_q,     len_d;
    logic [ADDR_W-1:0]   idx_q,     idx_d;
    logic [HALF_W-1:0]   hi_q,      hi_d;
    logic [HALF_W-1:0]   lo_q,      lo_d;
    logic [HALF_W-1:0]   chk_q,     chk_d;
    logic                chk_err_q, chk_err_d;
    logic                cpu_rst_q, cpu_rst_d;

    logic start_ok;
    logic xfer;
    logic last_word;

    assign start_ok  = start && (num_words != '0) &&
                       (num_words <= (ADDR_W+1)'(DEPTH));
    assign xfer      = in_valid && in_ready;
    // idx is compared zero-extended so len=DEPTH terminates at DEPTH-1 without wrapping.
    assign last_word = ({1'b0, idx_q} == (len_q - (ADDR_W+1)'(1)));

    always_ff @(posedge clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state_q   <= ST_IDLE;
            len_q     <= '0;
            idx_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            chk_q     <= '0;
            chk_err_q <= 1'b0;
            cpu_rst_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            idx_q     <= idx_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            chk_q     <= chk_d;
            chk_err_q <= chk_err_d;
            cpu_rst_q <= cpu_rst_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        idx_d     = idx_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        chk_d     = chk_q;
        chk_err_d = chk_err_q;
        cpu_rst_d = cpu_rst_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start_ok) begin
                    len_d     = num_words;
                    idx_d     = '0;
                    chk_d     = '0;
                    chk_err_d = 1'b0;
                    cpu_rst_d = 1'b1;
                    state_d   = ST_HI;
                end
            end
            ST_HI: begin
                if (xfer) begin
                    hi_d    = in_data;
                    chk_d   = chk_q ^ in_data;
                    state_d = ST_LO;
                end
            end
            ST_LO: begin
                if (xfer) begin
                    lo_d    = in_data;
                    chk_d   = chk_q ^ in_data;
                    state_d = ST_WR;
                end
            end
            ST_WR: begin
                if (last_word) begin
                    state_d = ST_CHK;
                end else begin
                    idx_d   = idx_q + ADDR_W'(1);
                    state_d = ST_HI;
                end
            end
            ST_CHK: begin
                if (xfer) begin
                    if (in_data == chk_q) begin
                        // CPU leaves reset in the same cycle done pulses.
                        cpu_rst_d = 1'b0;
                        state_d   = ST_DONE;
                    end else begin
                        chk_err_d = 1'b1;
                        state_d   = ST_IDLE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign in_ready  = (state_q == ST_HI) || (state_q == ST_LO) || (state_q == ST_CHK);
    assign mem_we    = (state_q == ST_WR);
    assign mem_addr  = idx_q;
    assign mem_wdata = {hi_q, lo_q};
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign chk_err   = chk_err_q;
    assign cpu_rst   = cpu_rst_q;

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: expected memory writes are queued by the stimulus
// and popped by a monitor that watches the write strobe.
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        sys_rst = 1'b0;
    logic        start = 1'b0;
    logic [4:0]  num_words = '0;
    logic [15:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        mem_we;
    logic [3:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_rst;
    logic        busy;
    logic        done;
    logic        chk_err;

    int checks = 0;
    int fails  = 0;
    int done_cnt = 0;
    logic [35:0] exp_q[$];
    logic [15:0] stim[0:31];

    prog_loader dut (
        .clk       (clk),
        .sys_rst   (sys_rst),
        .start     (start),
        .num_words (num_words),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_rst   (cpu_rst),
        .busy      (busy),
        .done      (done),
        .chk_err   (chk_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Monitor: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (sys_rst && mem_we) begin
            logic [35:0] e;
            if (exp_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_write: addr %h data %h, expected none", mem_addr, mem_wdata);
            end else begin
                e = exp_q.pop_front();
                check("write_addr", {28'd0, mem_addr}, {28'd0, e[35:32]});
                check("write_data", mem_wdata, e[31:0]);
                $display("write addr=%h data=%h", mem_addr, mem_wdata);
            end
        end
        if (sys_rst && done) done_cnt++;
    end

    task automatic send(input logic [15:0] d);
        int n = 0;
        in_data  = d;
        in_valid = 1'b1;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            fails++;
            $display("FAIL send_timeout: in_ready 0, expected 1 for data %h", d);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic do_start(input int n);
        start     = 1'b1;
        num_words = 5'(n);
        @(negedge clk);
        start     = 1'b0;
    endtask

    // Loads n words from stim[], queuing each expected write before its pair is sent.
    task automatic load(input int n, input logic [15:0] ck, input int gap);
        do_start(n);
        check("busy_after_start", {31'd0, busy}, 32'd1);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({4'(i), stim[2*i], stim[2*i+1]});
            send(stim[2*i]);
            for (int g = 0; g < gap; g++) begin
                check("ready_while_stalled", {31'd0, in_ready}, 32'd1);
                @(negedge clk);
            end
            send(stim[2*i+1]);
        end
        repeat (gap) @(negedge clk);
        send(ck);
        repeat (2) @(negedge clk);
    endtask

    task automatic set_t2;
        stim[0] = 16'h1234; stim[1] = 16'h5678;
        stim[2] = 16'h9ABC; stim[3] = 16'hDEF0;
    endtask

    initial begin
        int d0;
        // Test 1: reset values
        #12;
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_mem_we",   {31'd0, mem_we},   32'd0);
        check("rst_mem_addr", {28'd0, mem_addr}, 32'd0);
        check("rst_mem_wdata", mem_wdata,        32'd0);
        check("rst_cpu_rst",  {31'd0, cpu_rst},  32'd1);
        check("rst_busy",     {31'd0, busy},     32'd0);
        check("rst_done",     {31'd0, done},     32'd0);
        check("rst_chk_err",  {31'd0, chk_err},  32'd0);
        @(negedge clk);
        sys_rst = 1'b1;
        @(negedge clk);

        // Test 2: two words, good checksum
        set_t2();
        d0 = done_cnt;
        load(2, 16'h0000, 0);
        check("t2_done_once", done_cnt - d0, 1);
        check("t2_cpu_rst",   {31'd0, cpu_rst}, 32'd0);
        check("t2_chk_err",   {31'd0, chk_err}, 32'd0);
        check("t2_idle",      {31'd0, busy},    32'd0);
        $display("test2 two-word load complete");

        // Test 3: bad checksum
        d0 = done_cnt;
        load(2, 16'h0001, 0);
        check("t3_no_done", done_cnt - d0, 0);
        check("t3_chk_err", {31'd0, chk_err}, 32'd1);
        check("t3_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        $display("test3 bad checksum load complete");

        // Test 4: stalls between halfwords; accepted start clears chk_err
        d0 = done_cnt;
        do_start(17);
        check("t4_bad_start_ignored", {31'd0, busy}, 32'd0);
        check("t4_err_kept", {31'd0, chk_err}, 32'd1);
        load(2, 16'h0000, 5);
        check("t4_done_once", done_cnt - d0, 1);
        check("t4_chk_err",   {31'd0, chk_err}, 32'd0);
        check("t4_cpu_rst",   {31'd0, cpu_rst}, 32'd0);
        $display("test4 stalled load complete");

        // Test 5: full depth, then zero-length start ignored
        for (int k = 0; k < 32; k++) stim[k] = 16'(k);
        d0 = done_cnt;
        load(16, 16'h0000, 0);
        check("t5_done_once", done_cnt - d0, 1);
        check("t5_cpu_rst",   {31'd0, cpu_rst}, 32'd0);
        do_start(0);
        check("t5_zero_busy", {31'd0, busy},    32'd0);
        @(negedge clk);
        check("t5_zero_busy2", {31'd0, busy},   32'd0);
        check("t5_zero_cpu_rst", {31'd0, cpu_rst}, 32'd0);
        $display("test5 full-depth load complete");

        // Test 6: reset mid-load, then a clean one-word load
        for (int k = 0; k < 8; k++) stim[k] = 16'h1000 + 16'(k);
        do_start(4);
        exp_q.push_back({4'd0, stim[0], stim[1]});
        send(stim[0]);
        send(stim[1]);
        send(stim[2]);
        #2 sys_rst = 1'b0;
        #1;
        check("t6_busy",     {31'd0, busy},     32'd0);
        check("t6_mem_we",   {31'd0, mem_we},   32'd0);
        check("t6_cpu_rst",  {31'd0, cpu_rst},  32'd1);
        check("t6_in_ready", {31'd0, in_ready}, 32'd0);
        check("t6_queue_drained", exp_q.size(), 0);
        @(negedge clk);
        sys_rst = 1'b1;
        @(negedge clk);
        stim[0] = 16'hAAAA; stim[1] = 16'h5555;
        d0 = done_cnt;
        load(1, 16'hFFFF, 0);
        check("t6_done_once", done_cnt - d0, 1);
        check("t6_cpu_rst_released", {31'd0, cpu_rst}, 32'd0);
        $display("test6 reset recovery load complete");

        check("final_queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
